// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the UART Avalon-MM master
package uart_pkg;

    localparam logic [3:0] ADDR_TX   = 4'd0;
    localparam logic [3:0] ADDR_STAT = 4'd1;
    localparam logic [3:0] ADDR_RX   = 4'd2;

    localparam int STAT_READY = 0;
    localparam int STAT_BUSY  = 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RX_RD     = 3'd1;
    localparam logic [2:0] S_RX_WAIT   = 3'd2;
    localparam logic [2:0] S_POLL_RD   = 3'd3;
    localparam logic [2:0] S_POLL_WAIT = 3'd4;
    localparam logic [2:0] S_TX_WR     = 3'd5;
    localparam logic [2:0] S_SETTLE    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_RX_RD     = S_RX_RD,
        ST_RX_WAIT   = S_RX_WAIT,
        ST_POLL_RD   = S_POLL_RD,
        ST_POLL_WAIT = S_POLL_WAIT,
        ST_TX_WR     = S_TX_WR,
        ST_SETTLE    = S_SETTLE
    } uart_mst_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO holding bytes read from the UART RX register
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_avmm_master.sv
// rtl/uart_avmm_master.sv - Avalon-MM master feeding uart_core TX and draining its RX
module uart_avmm_master
    import uart_pkg::*;
#(
    parameter int RD_LATENCY    = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int RX_DEPTH      = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic       irq_i,
    output logic [3:0] avm_address_o,
    output logic       avm_byteenable_o,
    output logic       avm_read_o,
    output logic       avm_write_o,
    output logic [7:0] avm_writedata_o,
    input  logic [7:0] avm_readdata_i,
    output logic       rx_overflow_o,
    input  logic       clr_err_i,
    output logic       idle_o
);

    uart_mst_state_t state;
    logic [7:0]      cnt;
    logic [7:0]      tx_byte;
    logic            tx_held;
    logic            rx_pending;
    logic            rx_overflow;
    logic            rx_done;
    logic            poll_done;
    logic            settle_done;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            ovf_set;

    assign rx_done     = (state == ST_RX_WAIT)   && (cnt == 8'(RD_LATENCY - 1));
    assign poll_done   = (state == ST_POLL_WAIT) && (cnt == 8'(RD_LATENCY - 1));
    assign settle_done = (state == ST_SETTLE)    && (cnt == 8'(SETTLE_CYCLES - 1));

    assign fifo_push = rx_done && !fifo_full;
    assign fifo_pop  = rx_valid_o && rx_ready_i;

    // A second IRQ is only a loss if the pending one is not being retired this cycle.
    assign ovf_set = (irq_i && rx_pending && !rx_done) || (rx_done && fifo_full);

    assign tx_ready_o       = ~tx_held;
    assign rx_valid_o       = ~fifo_empty;
    assign rx_overflow_o    = rx_overflow;
    assign idle_o           = (state == ST_IDLE) && !tx_held && !rx_pending;
    assign avm_byteenable_o = 1'b1;
    assign avm_read_o       = (state == ST_RX_RD) || (state == ST_POLL_RD);
    assign avm_write_o      = (state == ST_TX_WR);
    assign avm_writedata_o  = (state == ST_TX_WR) ? tx_byte : 8'h00;

    always_comb begin
        avm_address_o = ADDR_TX;
        if (state == ST_RX_RD) begin
            avm_address_o = ADDR_RX;
        end else if (state == ST_POLL_RD) begin
            avm_address_o = ADDR_STAT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            tx_byte     <= 8'h00;
            tx_held     <= 1'b0;
            rx_pending  <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            if (tx_valid_i && !tx_held) begin
                tx_held <= 1'b1;
                tx_byte <= tx_data_i;
            end else if (state == ST_TX_WR) begin
                tx_held <= 1'b0;
            end

            if (irq_i) begin
                rx_pending <= 1'b1;
            end else if (rx_done) begin
                rx_pending <= 1'b0;
            end

            if (clr_err_i) begin
                rx_overflow <= 1'b0;
            end else if (ovf_set) begin
                rx_overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= 8'd0;
                    if (rx_pending) begin
                        state <= ST_RX_RD;
                    end else if (tx_held) begin
                        state <= ST_POLL_RD;
                    end
                end
                ST_RX_RD: begin
                    cnt   <= 8'd0;
                    state <= ST_RX_WAIT;
                end
                ST_RX_WAIT: begin
                    if (rx_done) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_POLL_RD: begin
                    cnt   <= 8'd0;
                    state <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    // Not-ready goes back through IDLE so RX can be serviced between retries.
                    if (poll_done) begin
                        state <= avm_readdata_i[STAT_READY] ? ST_TX_WR : ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_TX_WR: begin
                    cnt   <= 8'd0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push      (fifo_push),
        .push_data (avm_readdata_i),
        .pop       (fifo_pop),
        .pop_data  (rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_avmm_master.sv
// tb/tb_uart_avmm_master.sv - directed scoreboard bench for uart_avmm_master
module tb_uart_avmm_master;

    localparam int RD_LAT = 1;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b0;
    logic       irq_i = 1'b0;
    logic [3:0] avm_address_o;
    logic       avm_byteenable_o;
    logic       avm_read_o;
    logic       avm_write_o;
    logic [7:0] avm_writedata_o;
    logic [7:0] avm_readdata_i = 8'h00;
    logic       rx_overflow_o;
    logic       clr_err_i = 1'b0;
    logic       idle_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_count = 0;
    int wr_cyc = 0;
    int stat_reads = 0;
    int stat_cyc = 0;
    int rx_reads = 0;
    int rx_rd_stat = 0;
    int snap = 0;
    logic [7:0] stat_default = 8'h01;
    logic [7:0] stat_q[$];
    logic [7:0] rx_src_q[$];
    logic [7:0] exp_wr[$];
    logic [7:0] exp_rx[$];

    uart_avmm_master #(
        .RD_LATENCY    (RD_LAT),
        .SETTLE_CYCLES (2),
        .RX_DEPTH      (4)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .tx_data_i        (tx_data_i),
        .tx_valid_i       (tx_valid_i),
        .tx_ready_o       (tx_ready_o),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .rx_ready_i       (rx_ready_i),
        .irq_i            (irq_i),
        .avm_address_o    (avm_address_o),
        .avm_byteenable_o (avm_byteenable_o),
        .avm_read_o       (avm_read_o),
        .avm_write_o      (avm_write_o),
        .avm_writedata_o  (avm_writedata_o),
        .avm_readdata_i   (avm_readdata_i),
        .rx_overflow_o    (rx_overflow_o),
        .clr_err_i        (clr_err_i),
        .idle_o           (idle_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // uart_core register model: readdata registered one cycle after the read strobe
    always @(posedge clk_i) begin
        if (avm_read_o === 1'b1) begin
            if (avm_address_o == 4'd1) begin
                if (stat_q.size() != 0) avm_readdata_i <= stat_q.pop_front();
                else                    avm_readdata_i <= stat_default;
            end else if (avm_address_o == 4'd2) begin
                if (rx_src_q.size() != 0) avm_readdata_i <= rx_src_q.pop_front();
                else                      avm_readdata_i <= 8'h00;
            end else begin
                avm_readdata_i <= 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: pops the expected-write scoreboard on every write strobe
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            if (avm_write_o === 1'b1) begin
                wr_count++;
                wr_cyc = cyc;
                check("wr_addr", 32'(avm_address_o), 32'd0);
                check("wr_no_read", 32'(avm_read_o), 32'd0);
                check("wr_tx_ready_low", 32'(tx_ready_o), 32'd0);
                check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) check("wr_data", 32'(avm_writedata_o), 32'(exp_wr.pop_front()));
            end
            if (avm_read_o === 1'b1) begin
                if (avm_address_o == 4'd1) begin
                    stat_reads++;
                    stat_cyc = cyc;
                end else if (avm_address_o == 4'd2) begin
                    rx_reads++;
                    rx_rd_stat = stat_reads;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit expect_write);
        step();
        check("send_ready", 32'(tx_ready_o), 32'd1);
        tx_data_i = b;
        tx_valid_i = 1'b1;
        if (expect_write) exp_wr.push_back(b);
        step();
        tx_valid_i = 1'b0;
        check("tx_ready_after_accept", 32'(tx_ready_o), 32'd0);
    endtask

    task automatic wait_write(input int budget);
        int w0;
        bit saw_ready;
        w0 = wr_count;
        saw_ready = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (wr_count != w0) break;
            if (tx_ready_o) saw_ready = 1'b1;
        end
        check("write_seen", 32'(wr_count - w0), 32'd1);
        check("tx_ready_low_until_write", 32'(saw_ready), 32'd0);
    endtask

    task automatic wait_stat_read(input int budget);
        int s0;
        s0 = stat_reads;
        for (int i = 0; i < budget && stat_reads == s0; i++) step();
        check("stat_read_seen", 32'(stat_reads != s0), 32'd1);
    endtask

    task automatic wait_rx_read(input int budget);
        int r0;
        r0 = rx_reads;
        for (int i = 0; i < budget && rx_reads == r0; i++) step();
        check("rx_read_seen", 32'(rx_reads != r0), 32'd1);
    endtask

    task automatic pulse_irq();
        irq_i = 1'b1;
        step();
        irq_i = 1'b0;
    endtask

    task automatic drain_one();
        for (int i = 0; i < 20 && !rx_valid_o; i++) step();
        check("rx_valid", 32'(rx_valid_o), 32'd1);
        check("rx_exp_nonempty", 32'(exp_rx.size() != 0), 32'd1);
        if (exp_rx.size() != 0) check("rx_data", 32'(rx_data_o), 32'(exp_rx.pop_front()));
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        reset_n_i = 1'b1;
        check("rst_read", 32'(avm_read_o), 32'd0);
        check("rst_write", 32'(avm_write_o), 32'd0);
        check("rst_addr", 32'(avm_address_o), 32'd0);
        check("rst_wdata", 32'(avm_writedata_o), 32'd0);
        check("rst_byteen", 32'(avm_byteenable_o), 32'd1);
        check("rst_tx_ready", 32'(tx_ready_o), 32'd1);
        check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        check("rst_rx_data", 32'(rx_data_o), 32'd0);
        check("rst_overflow", 32'(rx_overflow_o), 32'd0);
        check("rst_idle", 32'(idle_o), 32'd1);

        // single TX with status ready
        stat_default = 8'h01;
        send(8'h48, 1'b1);
        wait_write(40);
        check("wr_latency", 32'(wr_cyc - stat_cyc), 32'(1 + RD_LAT));
        repeat (4) step();
        check("tx_ready_after_write", 32'(tx_ready_o), 32'd1);
        check("idle_after_tx", 32'(idle_o), 32'd1);

        // not-ready retry: three busy polls, then ready
        snap = stat_reads;
        stat_q.push_back(8'h02);
        stat_q.push_back(8'h02);
        stat_q.push_back(8'h02);
        stat_q.push_back(8'h01);
        send(8'h5a, 1'b1);
        wait_write(100);
        check("retry_poll_count", 32'(stat_reads - snap), 32'd4);
        repeat (4) step();

        // RX interrupt while a TX byte is held behind a busy UART
        stat_default = 8'h02;
        send(8'h41, 1'b1);
        wait_stat_read(20);
        rx_src_q.push_back(8'h65);
        exp_rx.push_back(8'h65);
        pulse_irq();
        snap = stat_reads;
        wait_rx_read(20);
        check("rx_before_next_poll", 32'(rx_rd_stat - snap), 32'd0);
        drain_one();
        stat_default = 8'h01;
        wait_write(60);
        repeat (4) step();

        // FIFO overflow: five bytes into four entries with no consumer
        for (int k = 0; k < 5; k++) begin
            rx_src_q.push_back(8'(8'h10 + k));
            if (k < 4) exp_rx.push_back(8'(8'h10 + k));
            pulse_irq();
            repeat (6) step();
            if (k == 3) check("no_overflow_at_full", 32'(rx_overflow_o), 32'd0);
        end
        check("overflow_set", 32'(rx_overflow_o), 32'd1);
        check("fifth_byte_read", 32'(rx_src_q.size()), 32'd0);
        check("idle_after_rx", 32'(idle_o), 32'd1);
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        check("overflow_cleared", 32'(rx_overflow_o), 32'd0);
        for (int k = 0; k < 4; k++) drain_one();
        check("fifo_drained", 32'(rx_valid_o), 32'd0);

        // double IRQ while in POLL_WAIT
        stat_default = 8'h02;
        send(8'h77, 1'b1);
        wait_stat_read(20);
        snap = rx_reads;
        rx_src_q.push_back(8'h99);
        exp_rx.push_back(8'h99);
        step();
        pulse_irq();
        pulse_irq();
        repeat (10) step();
        check("double_irq_one_read", 32'(rx_reads - snap), 32'd1);
        check("double_irq_overflow", 32'(rx_overflow_o), 32'd1);
        drain_one();
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        stat_default = 8'h01;
        wait_write(60);
        repeat (4) step();

        // reset during POLL_WAIT drops the held byte
        stat_default = 8'h01;
        send(8'h33, 1'b0);
        wait_stat_read(20);
        snap = wr_count;
        step();
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        check("midrst_read", 32'(avm_read_o), 32'd0);
        check("midrst_write", 32'(avm_write_o), 32'd0);
        check("midrst_addr", 32'(avm_address_o), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready_o), 32'd1);
        check("midrst_idle", 32'(idle_o), 32'd1);
        repeat (12) step();
        check("midrst_no_write", 32'(wr_count - snap), 32'd0);
        check("midrst_still_idle", 32'(idle_o), 32'd1);

        check("exp_wr_empty", 32'(exp_wr.size()), 32'd0);
        check("exp_rx_empty", 32'(exp_rx.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
